// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default line settings and
// the bit-period computation used by both the transmitter and the receiver.
package uart_tx_pkg;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 9600;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Clock cycles per serial bit (integer divide, truncating).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Handshake bundle between a byte producer and the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] Data;
    logic                 Tx;
    logic                 busy;
    logic                 finish;

    modport master (
        output tx_start,
        output Data,
        input  Tx,
        input  busy,
        input  finish
    );

    modport slave (
        input  tx_start,
        input  Data,
        output Tx,
        output busy,
        output finish
    );
endinterface

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each period. Also usable as the 16x oversampling tick source
// on the receive side.
module uart_tx_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_end = en && (cnt == CNT_LAST);

    // Period counter: cleared on request, wraps to zero at each bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity, STOP_BITS stop bits. The line is a registered copy of the bit the
// FSM is currently in, so Tx trails the state by one clock and never glitches.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bidx;
    logic                 par_bit;
    logic                 tx_r;
    logic                 tx_nxt;
    logic                 busy_r;
    logic                 fin_r;
    logic                 bit_end;
    logic                 accept;
    logic                 last_data;
    logic                 last_stop;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY_ODD != 0) ? ~^d : ^d;
    endfunction

    assign accept    = (state == S_IDLE) && bus.tx_start;
    assign last_data = (bidx == LAST_DATA);
    assign last_stop = (bidx == LAST_STOP);

    uart_tx_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state != S_IDLE),
        .clr     (state == S_IDLE),
        .bit_end (bit_end)
    );

    // Frame sequencing; every non-idle state advances only on a bit boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.tx_start) state_nxt = S_START;
            S_START:  if (bit_end) state_nxt = S_DATA;
            S_DATA:   if (bit_end && last_data)
                          state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            S_STOP:   if (bit_end && last_stop) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Line level for the bit the FSM is currently serialising.
    always_comb begin
        tx_nxt = 1'b1;
        case (state)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shreg[0];
            S_PARITY: tx_nxt = par_bit;
            default:  tx_nxt = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Byte capture with parity, then shift one data bit out per bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (accept) begin
            shreg   <= bus.Data;
            par_bit <= parity_of(bus.Data);
        end else if ((state == S_DATA) && bit_end) begin
            shreg   <= shreg >> 1;
        end
    end

    // Bit index, reused for data bits and then for stop bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bidx <= '0;
        end else if (state == S_IDLE) begin
            bidx <= '0;
        end else if (bit_end && (state == S_DATA || state == S_STOP)) begin
            if ((state == S_DATA && last_data) || (state == S_STOP && last_stop)) begin
                bidx <= '0;
            end else begin
                bidx <= bidx + 4'd1;
            end
        end
    end

    // Output registers: line, busy window and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
            fin_r  <= 1'b0;
        end else begin
            tx_r   <= tx_nxt;
            busy_r <= (state_nxt != S_IDLE);
            fin_r  <= (state == S_STOP) && bit_end && last_stop;
        end
    end

    assign bus.Tx     = tx_r;
    assign bus.busy   = busy_r;
    assign bus.finish = fin_r;

endmodule
